// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IF/LS sharing of one single-port memory, one outstanding transaction
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_bmask,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                rsp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_bmask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_n;
  logic owner, last, pick, sel_ls, tmo, done;
  logic [TW-1:0] timer;
  always_comb begin
    pick = if_req | ls_req;
    sel_ls = ls_req & (~if_req | ~last);
    tmo = timer == TW'(TIMEOUT - 1);
    done = mem_rvalid | tmo;
    state_n = state == IDLE ? (pick ? REQ : IDLE) :
              state == REQ  ? (mem_gnt ? RESP : REQ) :
                              (done ? IDLE : RESP);
    if_gnt = ~rst & (state == REQ) & mem_gnt & ~owner;
    ls_gnt = ~rst & (state == REQ) & mem_gnt & owner;
    stall = pick & ~(if_rvalid | ls_rvalid);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b0;
      timer <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_bmask <= '0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata <= '0;
      ls_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      timer <= (state == RESP && !done) ? timer + TW'(1) : '0;
      if_rvalid <= (state == RESP) & done & ~owner;
      ls_rvalid <= (state == RESP) & done & owner;
      rsp_err <= (state == RESP) & ~mem_rvalid & tmo;
      if_rdata <= ((state == RESP) & mem_rvalid & ~owner) ? mem_rdata : '0;
      ls_rdata <= ((state == RESP) & mem_rvalid & owner & ~mem_we) ? mem_rdata : '0;
      if (state == IDLE && pick) begin
        owner <= sel_ls;
        mem_req <= 1'b1;
        mem_we <= sel_ls & ls_we;
        mem_addr <= sel_ls ? ls_addr : if_addr;
        mem_wdata <= sel_ls ? ls_wdata : '0;
        mem_bmask <= sel_ls ? ls_bmask : '1;
      end
      if (state == REQ && mem_gnt) begin
        mem_req <= 1'b0;
        last <= owner;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 0, rst = 1;
  logic        if_req = 0, if_gnt, if_rvalid;
  logic [31:0] if_addr = 0, if_rdata;
  logic        ls_req = 0, ls_we = 0, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr = 0, ls_wdata = 0, ls_rdata;
  logic [3:0]  ls_bmask = 0;
  logic        rsp_err, mem_req, mem_we, stall;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  int vec = 0, mis = 0;
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_bmask(ls_bmask),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_bmask(mem_bmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(stall)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick;
    tick;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_bmask", 64'(mem_bmask), 64'd0);
    chk("rst_rvalid", 64'({if_rvalid, ls_rvalid, rsp_err, if_gnt, ls_gnt}), 64'd0);
    chk("rst_rdata", 64'({if_rdata, ls_rdata}), 64'd0);
    rst = 0;
    tick;
    if_req = 1; if_addr = 32'h10; mem_gnt = 1;
    #1;
    chk("f_stall_n", 64'(stall), 64'd1);
    chk("f_memreq_n", 64'(mem_req), 64'd0);
    tick;
    #1;
    chk("f_memreq", 64'(mem_req), 64'd1);
    chk("f_addr", 64'(mem_addr), 64'h10);
    chk("f_we", 64'(mem_we), 64'd0);
    chk("f_bmask", 64'(mem_bmask), 64'hF);
    chk("f_wdata", 64'(mem_wdata), 64'd0);
    chk("f_gnt", 64'({if_gnt, ls_gnt}), 64'b10);
    chk("f_stall_n1", 64'(stall), 64'd1);
    tick;
    mem_rvalid = 1; mem_rdata = 32'h0013_0093;
    #1;
    chk("f_stall_n2", 64'(stall), 64'd1);
    chk("f_memreq_n2", 64'(mem_req), 64'd0);
    chk("f_gnt_n2", 64'(if_gnt), 64'd0);
    tick;
    if_req = 0; mem_rvalid = 0;
    #1;
    chk("f_rvalid", 64'({if_rvalid, ls_rvalid, rsp_err}), 64'b100);
    chk("f_rdata", 64'(if_rdata), 64'h0013_0093);
    tick;
    #1;
    chk("f_rvalid_off", 64'(if_rvalid), 64'd0);
    chk("f_rdata_off", 64'(if_rdata), 64'd0);
    rst = 1;
    tick;
    rst = 0;
    tick;
    if_req = 1; ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_bmask = 4'h3;
    #1;
    tick;
    #1;
    chk("t_gnt", 64'({if_gnt, ls_gnt}), 64'b01);
    chk("t_addr", 64'(mem_addr), 64'h100);
    chk("t_we", 64'(mem_we), 64'd1);
    chk("t_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("t_bmask", 64'(mem_bmask), 64'h3);
    tick;
    ls_req = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    #1;
    tick;
    mem_rvalid = 0;
    #1;
    chk("t_ack", 64'({if_rvalid, ls_rvalid}), 64'b01);
    chk("t_ack_rdata", 64'(ls_rdata), 64'd0);
    tick;
    #1;
    chk("t_if_gnt", 64'({if_gnt, ls_gnt}), 64'b10);
    chk("t_if_addr", 64'(mem_addr), 64'h10);
    chk("t_if_bmask", 64'({mem_we, mem_bmask}), 64'h0F);
    tick;
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    #1;
    tick;
    mem_rvalid = 0;
    #1;
    chk("t_if_rdata", 64'({if_rvalid, if_rdata}), {31'd0, 1'b1, 32'hCAFE_F00D});
    tick;
    if_req = 1; ls_req = 1; ls_we = 0; ls_addr = 32'h200; if_addr = 32'h40;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hA5A5_0000;
    #1;
    for (int i = 0; i < 6; i++) begin
      tick;
      #1;
      chk($sformatf("rr_gnt%0d", i), 64'({if_gnt, ls_gnt}), (i % 2 == 0) ? 64'b01 : 64'b10);
      chk($sformatf("rr_addr%0d", i), 64'(mem_addr), (i % 2 == 0) ? 64'h200 : 64'h40);
      tick;
      tick;
      #1;
      chk($sformatf("rr_rv%0d", i), 64'({if_rvalid, ls_rvalid}), (i % 2 == 0) ? 64'b01 : 64'b10);
      chk($sformatf("rr_ld%0d", i), 64'(ls_rdata), (i % 2 == 0) ? 64'hA5A5_0000 : 64'd0);
      if (i == 5) begin
        if_req = 0; ls_req = 0; mem_rvalid = 0;
      end
    end
    tick;
    ls_req = 1; ls_we = 1; ls_addr = 32'h300; ls_wdata = 32'h1122_3344; ls_bmask = 4'hC; mem_gnt = 0;
    #1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      mem_gnt = (k == 6);
      #1;
      chk($sformatf("bp_req%0d", k), 64'(mem_req), 64'd1);
      chk($sformatf("bp_port%0d", k), {mem_we, mem_bmask, mem_addr[11:0], mem_wdata}, {1'b1, 4'hC, 12'h300, 32'h1122_3344});
      chk($sformatf("bp_gnt%0d", k), 64'(ls_gnt), 64'(k == 6));
    end
    for (int k = 0; k < 5; k++) begin
      tick;
      ls_req = 0; mem_gnt = 0; mem_rvalid = (k == 2); mem_rdata = 32'hFFFF_FFFF;
      #1;
      chk($sformatf("bp_rv%0d", k), 64'({ls_gnt, ls_rvalid, if_rvalid}), (k == 3) ? 64'b010 : 64'b000);
      chk($sformatf("bp_rd%0d", k), 64'(ls_rdata), 64'd0);
    end
    tick;
    ls_req = 1; ls_we = 0; ls_addr = 32'h400; mem_gnt = 1;
    #1;
    tick;
    #1;
    chk("to_gnt", 64'(ls_gnt), 64'd1);
    tick;
    ls_req = 0; mem_gnt = 0;
    #1;
    chk("to_entry", 64'(ls_rvalid), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      tick;
      mem_rvalid = (k == 8); mem_rdata = 32'h7777_7777;
      #1;
      chk($sformatf("to_rv%0d", k), 64'({ls_rvalid, rsp_err}), (k == 8) ? 64'b11 : 64'b00);
      chk($sformatf("to_rd%0d", k), 64'(ls_rdata), 64'd0);
    end
    tick;
    mem_rvalid = 0;
    #1;
    chk("to_late", 64'({ls_rvalid, if_rvalid, rsp_err, mem_req}), 64'd0);
    tick;
    ls_req = 1; ls_addr = 32'h600; mem_gnt = 1;
    #1;
    tick;
    #1;
    chk("ra_gnt", 64'(ls_gnt), 64'd1);
    tick;
    ls_req = 0; mem_gnt = 0; rst = 1;
    #1;
    chk("ra_gnt_off", 64'(ls_gnt), 64'd0);
    tick;
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h9999_9999;
    #1;
    chk("ra_port", {mem_req, mem_we, mem_bmask, mem_addr}, 64'd0);
    chk("ra_rv", 64'({ls_rvalid, if_rvalid, rsp_err}), 64'd0);
    tick;
    mem_rvalid = 0; if_req = 1; ls_req = 1; if_addr = 32'h700; ls_addr = 32'h800;
    ls_we = 1; ls_wdata = 32'h55; ls_bmask = 4'h1; mem_gnt = 1;
    #1;
    chk("ra_ignored", 64'({ls_rvalid, if_rvalid, mem_req}), 64'd0);
    tick;
    #1;
    chk("ra_tie_gnt", 64'({if_gnt, ls_gnt}), 64'b01);
    chk("ra_tie_addr", 64'(mem_addr), 64'h800);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequencer that shares one single-port memory between instruction fetch (IF) and load/store (LS). It arbitrates, registers the selected request onto the memory port, and tracks a single outstanding transaction. It routes the response back to the owner and raises a stall while the core waits. The block sits between the core datapath and the unified memory model and replaces the direct IMEM/DMEM connections.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte-mask width is DATA_W/8
TIMEOUT, 64, cycles to wait for mem_rvalid before forcing an error response (>=2)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  1-cycle pulse: fetch request accepted by memory
if_rvalid  out  1  1-cycle pulse: fetch data valid
if_rdata  out  DATA_W  fetch data
ls_req  in  1  load/store request; held until ls_gnt
ls_we  in  1  1 = store
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_bmask  in  DATA_W/8  store byte enables
ls_gnt  out  1  1-cycle pulse: LS request accepted
ls_rvalid  out  1  1-cycle pulse: load data / store ack valid
ls_rdata  out  DATA_W  load data; 0 for stores
rsp_err  out  1  qualifies the rvalid pulse in the same cycle: timeout occurred
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_bmask  out  DATA_W/8  memory byte enables; all-ones for reads
mem_gnt  in  1  memory accepts the current mem_req this cycle
mem_rvalid  in  1  memory response valid; arrives one or more cycles after mem_gnt
mem_rdata  in  DATA_W  memory read data
stall  out  1  combinational: (if_req|ls_req) & ~(if_rvalid|ls_rvalid)

Behaviour:
- Reset: state=IDLE, owner=IF, last=IF, timer=0. All registered outputs are 0: mem_*, *_gnt, *_rvalid, *_rdata, rsp_err.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one requester is asserting req, select it.
  - If both are asserting req, select the requester not in `last` (round-robin). The first tie after reset goes to LS.
  - On selection, register owner, addr, we, wdata and bmask onto mem_*, set mem_req=1, go to REQ. mem_req is asserted the cycle after the requester's req was sampled.
  - IF selection forces mem_we=0, mem_wdata=0, mem_bmask=all-ones.
- REQ:
  - Hold all mem_* outputs stable until mem_gnt=1.
  - In the mem_gnt cycle, pulse the owner's gnt combinationally. On the next edge set mem_req=0, last=owner, timer=0, and go to RESP.
  - There is no timeout in REQ.
- RESP:
  - On mem_rvalid=1, register mem_rdata into the owner's rdata (ls_rdata=0 for stores), pulse the owner's rvalid in the next cycle, and go to IDLE.
  - If timer reaches TIMEOUT-1 without mem_rvalid, pulse the owner's rvalid with rsp_err=1 and rdata=0, then go to IDLE.
  - A mem_rvalid arriving later for that transaction is ignored.
- Latency, zero-wait memory (mem_gnt same cycle as mem_req, mem_rvalid the following cycle):
  - req sampled at cycle N.
  - mem_req and gnt at N+1.
  - mem_rvalid at N+2.
  - owner rvalid at N+3.
- The arbiter allows only one outstanding transaction. The next arbitration happens in the same cycle the rvalid pulse is driven, i.e. IDLE is entered with that pulse.
- A requester must hold req, addr and data until its gnt. The latched copy is what gets issued, so input changes after selection are ignored.
- mem_rvalid while in IDLE or REQ is ignored and has no other side effect.
- Non-owner gnt, rvalid and rdata are held at 0 throughout.
- Reset asserted in any state aborts the transaction and returns to reset values on the next edge. No gnt or rvalid pulse is produced for the aborted request.
- The timer saturates and is cleared whenever the block leaves RESP.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0010; zero-wait memory returns 0x0013_0093 -> mem_req at N+1 with addr 0x10, we=0, bmask=0xF; if_rvalid=1 with if_rdata=0x0013_0093 at N+3; stall=1 during N..N+2.
- Tie after reset: if_req=ls_req=1 (ls_we=1, addr 0x100, wdata 0xDEADBEEF, bmask 0x3) -> LS issued first with mem_wdata=0xDEADBEEF, mem_bmask=0x3; ls_rdata=0 on ack; IF issued next, addr unchanged.
- Fairness: both requests held continuously for 6 transactions -> issue order LS, IF, LS, IF, LS, IF; no requester is granted twice in a row.
- Backpressure: mem_gnt low for 5 cycles then high; rvalid delayed 3 cycles -> mem_* stable for all 6 REQ cycles; exactly one gnt pulse and one rvalid pulse.
- Timeout: TIMEOUT=8; LS load granted, mem_rvalid never asserted -> ls_rvalid=1, rsp_err=1, ls_rdata=0 exactly 8 cycles after RESP entry; a late mem_rvalid produces no pulse.
- Reset mid-transaction: rst=1 during RESP -> next cycle all outputs 0, state IDLE; a subsequent mem_rvalid is ignored; the first tie after reset grants LS.
